// File: rtl/card_pair_controller_pkg.sv
// Shared types and helpers for the card pair controller: state encoding,
// move-counter width and timer sizing.
package card_pair_controller_pkg;

  typedef enum logic [3:0] {
    S_IDLE        = 4'd0,
    S_WAIT_FIRST  = 4'd1,
    S_RD_FIRST    = 4'd2,
    S_CAP_FIRST   = 4'd3,
    S_WAIT_SECOND = 4'd4,
    S_RD_SECOND   = 4'd5,
    S_CAP_SECOND  = 4'd6,
    S_COMPARE     = 4'd7,
    S_HOLD        = 4'd8,
    S_WON         = 4'd9
  } state_t;

  localparam int MOVES_W = 8;
  localparam logic [MOVES_W-1:0] MOVES_MAX = '1;

  // A one-cycle hold still needs a 1-bit counter.
  function automatic int timer_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/card_pair_controller_hold_timer.sv
// Loadable down-counter for the mismatch display time; done is asserted
// while running and the count has reached zero.
module card_pair_controller_hold_timer #(
  parameter int WIDTH = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_run,
  output logic             o_done
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_run && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_done = i_run && (r_count == '0);

endmodule

// File: rtl/card_pair_controller.sv
// Gameplay sequencer: accepts card clicks, fetches colours from the external
// colour memory, compares pairs and tracks moves, pairs and the win.
//
// state         | meaning
// S_IDLE        | game not active, counters held
// S_WAIT_FIRST  | waiting for the first card of a pair
// S_RD_FIRST    | colour memory read of first card in flight
// S_CAP_FIRST   | capture first colour
// S_WAIT_SECOND | waiting for the second card of a pair
// S_RD_SECOND   | colour memory read of second card in flight
// S_CAP_SECOND  | capture second colour
// S_COMPARE     | compare the two colours
// S_HOLD        | mismatched pair displayed until the timer expires
// S_WON         | all pairs found, outputs frozen until disabled
module card_pair_controller
  import card_pair_controller_pkg::*;
#(
  parameter int N_CARDS     = 16,
  parameter int IDX_W       = 4,
  parameter int COLOR_W     = 12,
  parameter int SHOW_CYCLES = 65_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_enable,
  input  logic               i_click_valid,
  input  logic [IDX_W-1:0]   i_click_card,
  output logic [IDX_W-1:0]   o_color_addr,
  input  logic [COLOR_W-1:0] i_color_data,
  output logic               o_click_ready,
  output logic [N_CARDS-1:0] o_revealed,
  output logic [N_CARDS-1:0] o_matched,
  output logic [MOVES_W-1:0] o_moves,
  output logic [IDX_W-1:0]   o_pairs,
  output logic               o_game_won
);

  localparam int TIMER_W = timer_width(SHOW_CYCLES);
  localparam logic [TIMER_W-1:0] HOLD_LOAD  = TIMER_W'(SHOW_CYCLES - 1);
  localparam logic [IDX_W-1:0]   PAIRS_ALL  = IDX_W'(N_CARDS / 2);
  localparam logic [IDX_W:0]     CARD_LIMIT = (IDX_W + 1)'(N_CARDS);
  localparam logic [N_CARDS-1:0] ONE_HOT0   = N_CARDS'(1);

  state_t             r_state;
  logic [IDX_W-1:0]   r_first_idx;
  logic [IDX_W-1:0]   r_second_idx;
  logic [COLOR_W-1:0] r_first_color;
  logic [COLOR_W-1:0] r_second_color;
  logic [IDX_W-1:0]   r_color_addr;
  logic               r_click_ready;
  logic [N_CARDS-1:0] r_revealed;
  logic [N_CARDS-1:0] r_matched;
  logic [MOVES_W-1:0] r_moves;
  logic [IDX_W-1:0]   r_pairs;
  logic               r_game_won;

  logic [N_CARDS-1:0] w_click_mask;
  logic [N_CARDS-1:0] w_pair_mask;
  logic               w_in_range;
  logic               w_click_free;
  logic               w_waiting;
  logic               w_accept;
  logic               w_colors_equal;
  logic [IDX_W-1:0]   w_pairs_next;
  logic               w_timer_load;
  logic               w_timer_run;
  logic               w_timer_done;

  // Out-of-range indices shift the one-hot to zero; w_in_range rejects them.
  assign w_click_mask   = ONE_HOT0 << i_click_card;
  assign w_pair_mask    = (ONE_HOT0 << r_first_idx) | (ONE_HOT0 << r_second_idx);
  assign w_in_range     = {1'b0, i_click_card} < CARD_LIMIT;
  assign w_click_free   = ((r_revealed | r_matched) & w_click_mask) == '0;
  assign w_waiting      = (r_state == S_WAIT_FIRST) || (r_state == S_WAIT_SECOND);
  assign w_accept       = i_click_valid && w_waiting && w_in_range && w_click_free;
  assign w_colors_equal = (r_first_color == r_second_color);
  assign w_pairs_next   = r_pairs + 1'b1;
  assign w_timer_load   = (r_state == S_COMPARE) && !w_colors_equal && i_enable;
  assign w_timer_run    = (r_state == S_HOLD);

  card_pair_controller_hold_timer #(
    .WIDTH(TIMER_W)
  ) u_hold_timer (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (!i_enable),
    .i_load    (w_timer_load),
    .i_load_val(HOLD_LOAD),
    .i_run     (w_timer_run),
    .o_done    (w_timer_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_first_idx    <= '0;
      r_second_idx   <= '0;
      r_first_color  <= '0;
      r_second_color <= '0;
      r_color_addr   <= '0;
      r_click_ready  <= 1'b0;
      r_revealed     <= '0;
      r_matched      <= '0;
      r_moves        <= '0;
      r_pairs        <= '0;
      r_game_won     <= 1'b0;
    end else if ((r_state != S_IDLE) && !i_enable) begin
      // Abandoned game: hide cards but keep the score visible until restart.
      r_state       <= S_IDLE;
      r_revealed    <= '0;
      r_click_ready <= 1'b0;
      r_game_won    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_enable) begin
            r_state       <= S_WAIT_FIRST;
            r_revealed    <= '0;
            r_matched     <= '0;
            r_moves       <= '0;
            r_pairs       <= '0;
            r_first_idx   <= '0;
            r_click_ready <= 1'b1;
          end
        end
        S_WAIT_FIRST: begin
          if (w_accept) begin
            r_state       <= S_RD_FIRST;
            r_revealed    <= r_revealed | w_click_mask;
            r_first_idx   <= i_click_card;
            r_color_addr  <= i_click_card;
            r_click_ready <= 1'b0;
          end
        end
        S_RD_FIRST: r_state <= S_CAP_FIRST;
        S_CAP_FIRST: begin
          r_first_color <= i_color_data;
          r_click_ready <= 1'b1;
          r_state       <= S_WAIT_SECOND;
        end
        S_WAIT_SECOND: begin
          if (w_accept) begin
            r_state       <= S_RD_SECOND;
            r_revealed    <= r_revealed | w_click_mask;
            r_second_idx  <= i_click_card;
            r_color_addr  <= i_click_card;
            r_click_ready <= 1'b0;
            if (r_moves != MOVES_MAX) r_moves <= r_moves + 1'b1;
          end
        end
        S_RD_SECOND: r_state <= S_CAP_SECOND;
        S_CAP_SECOND: begin
          r_second_color <= i_color_data;
          r_state        <= S_COMPARE;
        end
        S_COMPARE: begin
          if (w_colors_equal) begin
            r_matched  <= r_matched | w_pair_mask;
            r_revealed <= r_revealed & ~w_pair_mask;
            r_pairs    <= w_pairs_next;
            if (w_pairs_next == PAIRS_ALL) begin
              r_state    <= S_WON;
              r_game_won <= 1'b1;
            end else begin
              r_state       <= S_WAIT_FIRST;
              r_click_ready <= 1'b1;
            end
          end else begin
            r_state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (w_timer_done) begin
            r_revealed    <= r_revealed & ~w_pair_mask;
            r_click_ready <= 1'b1;
            r_state       <= S_WAIT_FIRST;
          end
        end
        S_WON: r_state <= S_WON;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_color_addr  = r_color_addr;
  assign o_click_ready = r_click_ready;
  assign o_revealed    = r_revealed;
  assign o_matched     = r_matched;
  assign o_moves       = r_moves;
  assign o_pairs       = r_pairs;
  assign o_game_won    = r_game_won;

endmodule

// File: tb/tb_card_pair_controller.sv
// Bench for card_pair_controller: directed vector table, a reset-mid-hold
// sequence, then random clicks against an event-scheduling game model.
module tb_card_pair_controller;

  localparam int N  = 4;
  localparam int IW = 3;
  localparam int CW = 12;
  localparam int SC = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          cv = 1'b0;
  logic [IW-1:0] card = '0;
  logic [IW-1:0] addr;
  logic [CW-1:0] cdata = '0;
  logic          rdy;
  logic [N-1:0]  rev;
  logic [N-1:0]  mat;
  logic [7:0]    mv;
  logic [IW-1:0] pr;
  logic          won;

  logic [CW-1:0] mem [0:7];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cdata <= mem[addr];

  card_pair_controller #(
    .N_CARDS(N), .IDX_W(IW), .COLOR_W(CW), .SHOW_CYCLES(SC)
  ) dut (
    .clk(clk), .rst(rst), .i_enable(en), .i_click_valid(cv), .i_click_card(card),
    .o_color_addr(addr), .i_color_data(cdata), .o_click_ready(rdy),
    .o_revealed(rev), .o_matched(mat), .o_moves(mv), .o_pairs(pr), .o_game_won(won)
  );

  // Reference model: game rules with timestamped pending events.
  localparam int EV_NONE = 0, EV_READY = 1, EV_CMP = 2, EV_UNHIDE = 3;
  bit         m_on, m_rdy, m_won, m_second;
  bit [N-1:0] m_rev, m_mat;
  int         m_mv, m_pr, m_addr, m_first, m_sec, m_ev, m_ev_at, m_cyc;

  task automatic model_reset();
    m_on = 0; m_rdy = 0; m_won = 0; m_second = 0; m_rev = '0; m_mat = '0;
    m_mv = 0; m_pr = 0; m_addr = 0; m_first = 0; m_sec = 0; m_ev = EV_NONE; m_ev_at = 0;
  endtask

  task automatic model_step(input bit e, input bit v, input int c);
    bit [N-1:0] both;
    m_cyc++;
    both = '0;
    both[m_first] = 1'b1;
    both[m_sec] = 1'b1;
    if (!m_on) begin
      if (e) begin
        m_on = 1; m_rev = '0; m_mat = '0; m_mv = 0; m_pr = 0;
        m_rdy = 1; m_second = 0; m_ev = EV_NONE;
      end
    end else if (!e) begin
      m_on = 0; m_rev = '0; m_rdy = 0; m_won = 0; m_ev = EV_NONE;
    end else if (m_won) begin
      m_won = 1;
    end else if (m_ev != EV_NONE && m_cyc == m_ev_at) begin
      case (m_ev)
        EV_READY: begin m_rdy = 1; m_second = 1; m_ev = EV_NONE; end
        EV_CMP: begin
          // Even cards are one colour, odd cards the other.
          if ((m_first % 2) == (m_sec % 2)) begin
            m_mat = m_mat | both; m_rev = m_rev & ~both; m_pr++; m_ev = EV_NONE;
            if (m_pr == N / 2) m_won = 1;
            else begin m_rdy = 1; m_second = 0; end
          end else begin
            m_ev = EV_UNHIDE; m_ev_at = m_cyc + SC;
          end
        end
        default: begin m_rev = m_rev & ~both; m_rdy = 1; m_second = 0; m_ev = EV_NONE; end
      endcase
    end else if (m_rdy && v && c < N && !m_rev[c] && !m_mat[c]) begin
      m_rev[c] = 1'b1; m_rdy = 0; m_addr = c;
      if (!m_second) begin
        m_first = c; m_ev = EV_READY; m_ev_at = m_cyc + 2;
      end else begin
        m_sec = c; if (m_mv < 255) m_mv++;
        m_ev = EV_CMP; m_ev_at = m_cyc + 3;
      end
    end
  endtask

  task automatic check(input string name, input bit [N-1:0] erev, input bit [N-1:0] emat,
                       input int emv, input int epr, input bit erdy, input bit ewon, input int eaddr);
    n_vec++;
    if (rev !== erev || mat !== emat || int'(mv) != emv || int'(pr) != epr ||
        rdy !== erdy || won !== ewon || int'(addr) != eaddr) begin
      n_err++;
      $display("FAIL %s: got rev=%b mat=%b moves=%0d pairs=%0d ready=%b won=%b addr=%0d, want rev=%b mat=%b moves=%0d pairs=%0d ready=%b won=%b addr=%0d",
               name, rev, mat, mv, pr, rdy, won, addr, erev, emat, emv, epr, erdy, ewon, eaddr);
    end
  endtask

  task automatic drive(input bit e, input bit v, input int c);
    en = e; cv = v; card = IW'(c);
    @(posedge clk);
    if (rst) model_reset();
    else model_step(e, v, c);
    #1;
  endtask

  typedef struct {
    bit en; bit cv; int card;
    bit [N-1:0] rev; bit [N-1:0] mat; int mv; int pr; bit rdy; bit won; int addr;
  } vec_t;

  vec_t vt[45];

  function automatic vec_t mk(bit e, bit v, int c, bit [N-1:0] r, bit [N-1:0] m,
                              int mvs, int p, bit rd, bit w, int a);
    vec_t x;
    x.en = e; x.cv = v; x.card = c; x.rev = r; x.mat = m;
    x.mv = mvs; x.pr = p; x.rdy = rd; x.won = w; x.addr = a;
    return x;
  endfunction

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = (i >= N) ? 12'hFFF : ((i % 2 == 0) ? 12'hA0A : 12'h0B0);

    // Game 1: re-click, out-of-range click, mismatch with click during hold, then full win.
    vt[0]  = mk(1,0,0, 4'b0000,4'b0000,0,0,1,0,0);
    vt[1]  = mk(1,1,0, 4'b0001,4'b0000,0,0,0,0,0);
    vt[2]  = mk(1,0,0, 4'b0001,4'b0000,0,0,0,0,0);
    vt[3]  = mk(1,0,0, 4'b0001,4'b0000,0,0,1,0,0);
    vt[4]  = mk(1,1,0, 4'b0001,4'b0000,0,0,1,0,0);
    vt[5]  = mk(1,1,5, 4'b0001,4'b0000,0,0,1,0,0);
    vt[6]  = mk(1,1,1, 4'b0011,4'b0000,1,0,0,0,1);
    vt[7]  = mk(1,0,0, 4'b0011,4'b0000,1,0,0,0,1);
    vt[8]  = mk(1,0,0, 4'b0011,4'b0000,1,0,0,0,1);
    vt[9]  = mk(1,0,0, 4'b0011,4'b0000,1,0,0,0,1);
    vt[10] = mk(1,1,2, 4'b0011,4'b0000,1,0,0,0,1);
    vt[11] = mk(1,0,0, 4'b0011,4'b0000,1,0,0,0,1);
    vt[12] = mk(1,0,0, 4'b0011,4'b0000,1,0,0,0,1);
    vt[13] = mk(1,0,0, 4'b0000,4'b0000,1,0,1,0,1);
    vt[14] = mk(1,1,0, 4'b0001,4'b0000,1,0,0,0,0);
    vt[15] = mk(1,0,0, 4'b0001,4'b0000,1,0,0,0,0);
    vt[16] = mk(1,0,0, 4'b0001,4'b0000,1,0,1,0,0);
    vt[17] = mk(1,1,2, 4'b0101,4'b0000,2,0,0,0,2);
    vt[18] = mk(1,0,0, 4'b0101,4'b0000,2,0,0,0,2);
    vt[19] = mk(1,0,0, 4'b0101,4'b0000,2,0,0,0,2);
    vt[20] = mk(1,0,0, 4'b0000,4'b0101,2,1,1,0,2);
    vt[21] = mk(1,1,3, 4'b1000,4'b0101,2,1,0,0,3);
    vt[22] = mk(1,0,0, 4'b1000,4'b0101,2,1,0,0,3);
    vt[23] = mk(1,0,0, 4'b1000,4'b0101,2,1,1,0,3);
    vt[24] = mk(1,1,1, 4'b1010,4'b0101,3,1,0,0,1);
    vt[25] = mk(1,0,0, 4'b1010,4'b0101,3,1,0,0,1);
    vt[26] = mk(1,0,0, 4'b1010,4'b0101,3,1,0,0,1);
    vt[27] = mk(1,0,0, 4'b0000,4'b1111,3,2,0,1,1);
    vt[28] = mk(1,1,0, 4'b0000,4'b1111,3,2,0,1,1);
    vt[29] = mk(1,0,0, 4'b0000,4'b1111,3,2,0,1,1);
    vt[30] = mk(0,0,0, 4'b0000,4'b1111,3,2,0,0,1);
    vt[31] = mk(0,0,0, 4'b0000,4'b1111,3,2,0,0,1);
    // Game 2: disable mid-hold with a simultaneous click, then restart.
    vt[32] = mk(1,0,0, 4'b0000,4'b0000,0,0,1,0,1);
    vt[33] = mk(1,1,0, 4'b0001,4'b0000,0,0,0,0,0);
    vt[34] = mk(1,0,0, 4'b0001,4'b0000,0,0,0,0,0);
    vt[35] = mk(1,0,0, 4'b0001,4'b0000,0,0,1,0,0);
    vt[36] = mk(1,1,1, 4'b0011,4'b0000,1,0,0,0,1);
    vt[37] = mk(1,0,0, 4'b0011,4'b0000,1,0,0,0,1);
    vt[38] = mk(1,0,0, 4'b0011,4'b0000,1,0,0,0,1);
    vt[39] = mk(1,0,0, 4'b0011,4'b0000,1,0,0,0,1);
    vt[40] = mk(1,0,0, 4'b0011,4'b0000,1,0,0,0,1);
    vt[41] = mk(0,1,2, 4'b0000,4'b0000,1,0,0,0,1);
    vt[42] = mk(1,0,0, 4'b0000,4'b0000,0,0,1,0,1);
    vt[43] = mk(0,1,0, 4'b0000,4'b0000,0,0,0,0,1);
    vt[44] = mk(0,0,0, 4'b0000,4'b0000,0,0,0,0,1);

    model_reset();
    m_cyc = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset", '0, '0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 45; i++) begin
      drive(vt[i].en, vt[i].cv, vt[i].card);
      check($sformatf("table[%0d]", i), vt[i].rev, vt[i].mat, vt[i].mv, vt[i].pr,
            vt[i].rdy, vt[i].won, vt[i].addr);
    end

    // Reset in the middle of a hold, then a fresh start.
    drive(1, 0, 0);
    drive(1, 1, 0);
    drive(1, 0, 0);
    drive(1, 0, 0);
    drive(1, 1, 3);
    drive(1, 0, 0);
    drive(1, 0, 0);
    drive(1, 0, 0);
    check("hold_entered", 4'b1001, '0, 1, 0, 0, 0, 3);
    rst = 1'b1;
    drive(1, 0, 0);
    rst = 1'b0;
    check("rst_mid_hold", '0, '0, 0, 0, 0, 0, 0);
    drive(1, 0, 0);
    check("restart_after_rst", '0, '0, 0, 0, 1, 0, 0);

    // Random play against the model.
    rst = 1'b1;
    drive(0, 0, 0);
    rst = 1'b0;
    check("random_reset", m_rev, m_mat, m_mv, m_pr, m_rdy, m_won, m_addr);
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      drive($urandom_range(0, 99) != 0, $urandom_range(0, 1) == 1, int'($urandom_range(0, 7)));
      rst = 1'b0;
      check($sformatf("random[%0d]", i), m_rev, m_mat, m_mv, m_pr, m_rdy, m_won, m_addr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
